// File: rtl/cpu_pkg.sv
// Purpose: shared CPU constants and types for the EX-stage divide path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN = 32;

    // Result the unsigned core produces for a zero divisor; passed to HI/LO
    // without sign correction.
    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'h0000_0000;
    localparam logic [XLEN-1:0] DIV_ZERO_R = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Two's-complement magnitude when neg is set. |0x80000000| stays
    // 0x80000000, which the unsigned core reads correctly as 2^31.
    function automatic logic [XLEN-1:0] mag_of(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/division.sv
// Purpose: combinational unsigned restoring divider (quotient/remainder).
// Latency: purely combinational; callers hold inputs for a multicycle budget.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   i_dividend, i_divisor : unsigned operands
//   o_quotient, o_remainder : unsigned results; divisor 0 gives DIV_ZERO_Q/R
module division
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    logic [XLEN:0]   w_rem;
    logic [XLEN-1:0] w_quo;

    // One extra remainder bit so the shifted partial remainder never
    // overflows before the compare against the divisor.
    always_comb begin
        w_rem = '0;
        w_quo = '0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            w_rem = {w_rem[XLEN-1:0], i_dividend[i]};
            if (w_rem >= {1'b0, i_divisor}) begin
                w_rem    = w_rem - {1'b0, i_divisor};
                w_quo[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (i_divisor == '0) begin
            o_quotient  = DIV_ZERO_Q;
            o_remainder = DIV_ZERO_R;
        end else begin
            o_quotient  = w_quo;
            o_remainder = w_rem[XLEN-1:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// Purpose: EX-stage DIV/DIVU controller; latches magnitudes, drives the core, sign-fixes results.
// Latency: start at edge k -> results registered at edge k+LATENCY, done high the following cycle.
// Backpressure: stall held while a start is being accepted and throughout CALC; flush aborts.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start, is_signed    : divide request (sampled in IDLE/DONE); 1 = DIV, 0 = DIVU
//   dividend, divisor   : 32-bit operands
//   flush               : aborts any operation, wins over start and over capture
//   stall               : combinational pipeline stall request
//   busy, done          : registered; busy in CALC, done one-cycle pulse after capture
//   quotient, remainder : LO/HI results, held between operations
//   div_zero            : registered with done; latched divisor was zero
module div_unit
    import cpu_pkg::*;
#(
    parameter int LATENCY = 4,   // cycles held in CALC, >= 1
    parameter int CNT_W   = 3    // 2**CNT_W must exceed LATENCY
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_zero
);

    div_state_t      r_state;
    div_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_dvd_mag;
    logic [XLEN-1:0] r_dvs_mag;
    logic            r_sign_q;
    logic            r_sign_r;
    logic [XLEN-1:0] r_quotient;
    logic [XLEN-1:0] r_remainder;
    logic            r_done;
    logic            r_busy;
    logic            r_div_zero;

    logic            w_latch;
    logic            w_capture;
    logic            w_dec;
    logic            w_stall;
    logic            w_dvs_zero;
    logic [XLEN-1:0] w_core_q;
    logic [XLEN-1:0] w_core_r;

    division u_division (
        .i_dividend  (r_dvd_mag),
        .i_divisor   (r_dvs_mag),
        .o_quotient  (w_core_q),
        .o_remainder (w_core_r)
    );

    // Magnitude is zero only when the original divisor was zero.
    assign w_dvs_zero = (r_dvs_mag == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_dec        = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_next_state = CALC;
                    w_latch      = 1'b1;
                    w_stall      = 1'b1;
                end
            end
            CALC: begin
                w_stall = 1'b1;
                // Flush is checked first so it also beats a same-cycle capture.
                if (flush) begin
                    w_next_state = IDLE;
                end else if (r_cnt != '0) begin
                    w_dec = 1'b1;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (start && !flush) begin
                    w_next_state = CALC;
                    w_latch      = 1'b1;
                    w_stall      = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_dvd_mag <= '0;
            r_dvs_mag <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
        end else begin
            if (w_latch) begin
                r_cnt     <= CNT_W'(LATENCY - 1);
                r_dvd_mag <= mag_of(is_signed & dividend[XLEN-1], dividend);
                r_dvs_mag <= mag_of(is_signed & divisor[XLEN-1], divisor);
                r_sign_q  <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                r_sign_r  <= is_signed & dividend[XLEN-1];
            end else if (w_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= w_capture;
            r_busy <= (w_next_state == CALC);
            if (w_capture) begin
                r_div_zero <= w_dvs_zero;
                // Divide-by-zero result bypasses sign correction.
                if (w_dvs_zero) begin
                    r_quotient  <= w_core_q;
                    r_remainder <= w_core_r;
                end else begin
                    r_quotient  <= r_sign_q ? -w_core_q : w_core_q;
                    r_remainder <= r_sign_r ? -w_core_r : w_core_r;
                end
            end
        end
    end

    assign stall     = w_stall;
    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.LATENCY(LAT), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives start for one cycle, returns at the negedge of the first CALC cycle.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle index (first CALC cycle = 1) at which done is seen; flags stall/busy drops before it.
    task automatic wait_done(output int cyc, output logic calc_bad);
        cyc      = 1;
        calc_bad = 1'b0;
        while (!done && cyc < 40) begin
            if (!stall || !busy) calc_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    // Watches n cycles for any done pulse.
    task automatic watch_no_done(input int n, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    int   cyc;
    logic bad;
    logic seen;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'h0,          32'hFFFF_FFFF,  1'b1};
        vecs[4]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'h0,          32'hFFFF_FFFF,  1'b1};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[10] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[11] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        flush     = 1'b0;
        #12;
        check("rst_quotient",  quotient,  32'h0);
        check("rst_remainder", remainder, 32'h0);
        check("rst_done",      {31'b0, done},     32'h0);
        check("rst_busy",      {31'b0, busy},     32'h0);
        check("rst_div_zero",  {31'b0, div_zero}, 32'h0);
        check("rst_stall",     {31'b0, stall},    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            start     = 1'b1;
            is_signed = vecs[i].s;
            dividend  = vecs[i].a;
            divisor   = vecs[i].b;
            #1;
            check($sformatf("v%0d_stall_issue", i), {31'b0, stall}, 32'h1);
            @(negedge clk);
            start = 1'b0;
            wait_done(cyc, bad);
            check($sformatf("v%0d_latency", i),   cyc, LAT + 1);
            check($sformatf("v%0d_calc_stall", i), {31'b0, bad}, 32'h0);
            check($sformatf("v%0d_quotient", i),  quotient,  vecs[i].q);
            check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            check($sformatf("v%0d_div_zero", i),  {31'b0, div_zero}, {31'b0, vecs[i].dz});
            check($sformatf("v%0d_done_stall", i), {31'b0, stall}, 32'h0);
            check($sformatf("v%0d_done_busy", i),  {31'b0, busy},  32'h0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
        end

        // Flush two cycles into CALC: abort, results held (last: 14 / 0xFFFFFFFE)
        issue(1'b0, 32'd50, 32'd5);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy",  {31'b0, busy},  32'h0);
        check("flush_stall", {31'b0, stall}, 32'h0);
        watch_no_done(8, seen);
        check("flush_no_done",   {31'b0, seen}, 32'h0);
        check("flush_quotient",  quotient,  32'd14);
        check("flush_remainder", remainder, 32'hFFFF_FFFE);

        // Flush in the capture cycle (cnt==0): flush wins
        issue(1'b0, 32'd50, 32'd5);
        repeat (LAT - 1) @(negedge clk);
        check("capflush_busy_before", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        watch_no_done(8, seen);
        check("capflush_no_done",   {31'b0, seen}, 32'h0);
        check("capflush_quotient",  quotient,  32'd14);
        check("capflush_remainder", remainder, 32'hFFFF_FFFE);

        // Start and flush together in IDLE: dropped
        start    = 1'b1;
        flush    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        #1;
        check("idleflush_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("idleflush_busy", {31'b0, busy}, 32'h0);
        watch_no_done(8, seen);
        check("idleflush_no_done", {31'b0, seen}, 32'h0);

        // Back-to-back: new start in the DONE cycle
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bad);
        check("b2b_a_latency",  cyc, LAT + 1);
        check("b2b_a_quotient", quotient, 32'hFFFF_FFFD);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        #1;
        check("b2b_stall_in_done", {31'b0, stall}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bad);
        check("b2b_b_latency",    cyc, LAT + 1);
        check("b2b_b_calc_stall", {31'b0, bad}, 32'h0);
        check("b2b_b_quotient",   quotient,  32'd10);
        check("b2b_b_remainder",  remainder, 32'd0);
        @(negedge clk);

        // Async reset mid-CALC
        issue(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_quotient",  quotient,  32'h0);
        check("arst_remainder", remainder, 32'h0);
        check("arst_busy",      {31'b0, busy},     32'h0);
        check("arst_done",      {31'b0, done},     32'h0);
        check("arst_div_zero",  {31'b0, div_zero}, 32'h0);
        check("arst_stall",     {31'b0, stall},    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done(6, seen);
        check("arst_no_done", {31'b0, seen}, 32'h0);

        // Works again after reset
        issue(1'b0, 32'd100, 32'd7);
        wait_done(cyc, bad);
        check("post_rst_latency",   cyc, LAT + 1);
        check("post_rst_quotient",  quotient,  32'd14);
        check("post_rst_remainder", remainder, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
EX-stage multicycle divide controller for DIV/DIVU.
- Accepts a start request from decode/EX and converts signed operands to magnitudes.
- Drives the team's combinational unsigned `division` core and holds the operands stable for a fixed multicycle budget.
- Registers the sign-corrected quotient/remainder for HI/LO writeback, and stalls the pipeline until the result is ready.

Parameters:
LATENCY, 4, cycles the operands are held in CALC before results are captured (>=1; multicycle path budget for the divider core)
CNT_W, 3, counter width; must satisfy 2**CNT_W > LATENCY

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a divide; sampled in IDLE or DONE
is_signed  input  1  1 = DIV (signed), 0 = DIVU
dividend  input  32  dividend operand
divisor  input  32  divisor operand
flush  input  1  pipeline flush; aborts any operation in progress
stall  output  1  pipeline stall request (combinational)
busy  output  1  registered; high in CALC
done  output  1  one-cycle pulse; quotient/remainder valid and updated
quotient  output  32  result for LO
remainder  output  32  result for HI
div_zero  output  1  registered with done; divisor was 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, quotient=0, remainder=0, done=0, busy=0, div_zero=0. Operand registers are cleared. Reset mid-CALC aborts with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 -> latch operands; cnt<=LATENCY-1; go to CALC.
  - flush=1 -> stay in IDLE; the start is dropped.
- CALC:
  - busy=1; start is ignored.
  - flush=1 -> IDLE; outputs unchanged; no done.
  - cnt!=0 -> cnt<=cnt-1.
  - cnt==0 -> capture results; go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 and flush=0 -> latch new operands; go to CALC (back-to-back issue).
  - Otherwise -> IDLE.
- Latency: start sampled at edge k. CALC occupies cycles k+1..k+LATENCY. Results are registered at edge k+LATENCY and done is high during cycle k+LATENCY+1.
- stall = (start & ~flush & (state==IDLE | state==DONE)) | (state==CALC). Stall is low in DONE unless a new start arrives.
- Operand latch: sign_q = is_signed & (dividend[31]^divisor[31]); sign_r = is_signed & dividend[31].
  - Magnitudes: if is_signed and the msb is set, two's-complement negate; otherwise pass through.
  - |0x80000000| = 0x80000000, interpreted as unsigned.
- Core outputs are corrected as follows: quotient = sign_q ? -q : q; remainder = sign_r ? -r : r. All arithmetic is modulo 2^32.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. Wraps with no flag.
- Divisor==0 (latched): the core's result passes through with no sign correction. quotient=0x00000000, remainder=0xFFFFFFFF, div_zero=1.
- div_zero updates only on the capture edge. It is cleared on the next capture with a nonzero divisor.
- quotient/remainder hold their values between operations; only a capture or reset changes them.
- Simultaneous flush and capture (cnt==0): flush wins; no capture, no done.

Decomposition:
- Shared package cpu_pkg:
  - div_state_t enum (IDLE, CALC, DONE).
  - DIV_ZERO_Q = 32'h0.
  - DIV_ZERO_R = 32'hFFFFFFFF.
  - Data width constant XLEN=32.
- One sub-module: the existing combinational unsigned `division` core, instantiated once and fed from the latched magnitude registers.
- Sign fixup and the FSM stay in div_unit.

Test Plan:
- DIVU 100/7, LATENCY=4 -> stall high in cycles k..k+4, done in cycle k+5, quotient=14, remainder=2, div_zero=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- DIV 5/0 -> quotient=0, remainder=0xFFFFFFFF, div_zero=1. A following DIVU 9/3 -> quotient=3, remainder=0, div_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Start DIVU 50/5, then assert flush at cycle k+2 -> state returns to IDLE, no done, quotient/remainder keep their previous values. Also: start+flush in the same IDLE cycle -> no operation, stall low.
- Back-to-back: start asserted again in the DONE cycle -> second result with done exactly LATENCY+1 cycles later. Assert rst_n=0 mid-CALC -> all outputs 0 immediately, asynchronously.
